mem_arbiter_rr: RTL
===================

# mem_arbiter_rr

Parametrised N-port memory arbiter between the L1 caches / eviction buffer and the single physical-memory port. It grants one line-sized request at a time using round-robin priority. It serialises cache-line writes into bus-width bursts and reassembles read bursts into a full line. It replaces the fixed two-port instruction/data arbiter and scales to extra requesters such as a prefetcher or an L2.

## Interface
Parameters:
- NUM_PORTS, 2, number of requesters (≥2).
- ADDR_WIDTH, 32, address width.
- LINE_WIDTH, 256, cache-line width in bits.
- BUS_WIDTH, 64, physical-memory beat width. LINE_WIDTH must be a multiple of it. BEATS = LINE_WIDTH/BUS_WIDTH.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_read  in  NUM_PORTS  per-port line read request (level).
- req_write  in  NUM_PORTS  per-port line write request (level).
- req_addr  in  NUM_PORTS*ADDR_WIDTH  per-port line address. Port i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_PORTS*LINE_WIDTH  per-port write line, sliced the same way.
- req_rdata  out  LINE_WIDTH  assembled read line, shared by all ports.
- req_resp  out  NUM_PORTS  one-hot, one-cycle completion pulse.
- grant  out  NUM_PORTS  one-hot currently served port, 0 when idle.
- pmem_read  out  1  memory read, held for the whole burst.
- pmem_write  out  1  memory write, held for the whole burst.
- pmem_addr  out  ADDR_WIDTH  line address of the granted port.
- pmem_wdata  out  BUS_WIDTH  current write beat.
- pmem_rdata  in  BUS_WIDTH  read beat.
- pmem_resp  in  1  beat accepted/valid.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - Port i is requesting when req_read[i] | req_write[i].
  - The winner is the first requesting port found by searching upward from rr_ptr, with wrap.
  - Next state is WRITE if req_write[winner], else READ. Write wins if both are set on the same port.
  - The winner index, address and (for writes) wdata line are latched. Later changes to request inputs are ignored until RESP.
- READ:
  - pmem_read=1.
  - Each cycle pmem_resp=1, capture pmem_rdata into line[beat*BUS_WIDTH +: BUS_WIDTH] and increment beat.
  - The BEATS-th resp moves the FSM to RESP.
- WRITE:
  - pmem_write=1 and pmem_wdata = latched_line[beat*BUS_WIDTH +: BUS_WIDTH].
  - beat advances on each pmem_resp.
  - The BEATS-th resp moves the FSM to RESP.
- RESP:
  - req_resp[winner]=1 for exactly one cycle.
  - req_rdata holds the assembled line and stays stable until the next read completes.
  - rr_ptr ← (winner+1) mod NUM_PORTS.
  - Next state is IDLE.
- Protocol: a requester deasserts its request in the cycle after its req_resp. The arbiter does not enforce this. A request still high in IDLE is treated as new.
- grant is one-hot of the latched winner in READ/WRITE/RESP, 0 in IDLE.
- pmem_addr holds the latched address during bursts and is 0 in IDLE.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0, beat=0.
  - pmem_read=pmem_write=0, pmem_addr=0, pmem_wdata=0.
  - req_resp=0, grant=0, req_rdata=0.
- Reset mid-burst aborts immediately; the next cycle is IDLE with all outputs at reset values. Memory must tolerate an abandoned burst.
- Request sampled in IDLE at cycle t → pmem_read/pmem_write asserted at t+1.
- Last beat's pmem_resp at cycle r → req_resp at r+1 → IDLE at r+2.
- Minimum occupancy per transaction: BEATS+2 cycles (zero-wait memory).
- The beat counter is $clog2(BEATS) bits wide and must not overflow. Extra pmem_resp in IDLE/RESP is ignored.
- Simultaneous requests from all ports: each is served once within NUM_PORTS transactions (round-robin).

## Configuration
- MEM_ARB_FIXED_PRIO_EN defined: the IDLE search always starts at port 0 (lowest index wins). rr_ptr is not instantiated, and starvation is possible.
- Not defined: round-robin behaviour as described above.

## Test plan
- Port 0 read at addr 0x100, memory returns beats 0xA,0xB,0xC,0xD one per cycle → pmem_addr=0x100 held for 4 cycles; req_rdata={0xD,0xC,0xB,0xA}; req_resp=2'b01 exactly once, one cycle after the 4th beat.
- Port 1 write of line {0x4,0x3,0x2,0x1} with 2 wait cycles per beat → pmem_wdata sequence 0x1,0x2,0x3,0x4, each held until its pmem_resp; req_resp=2'b10 once.
- Both ports request continuously, re-requesting after resp, 4 transactions → grant order 0,1,0,1. With MEM_ARB_FIXED_PRIO_EN, grant order 0,0,0,0.
- NUM_PORTS=3, all requesting after port 1 was last served → order 2,0,1.
- rst asserted after the 2nd beat of a read → next cycle pmem_read=0, grant=0, no req_resp. A fresh request then completes normally with beat index restarting at 0.
- Port 0 asserts req_read and req_write together → WRITE burst performed, no read.

Source files
------------

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - N-port round-robin line arbiter with burst serialise/reassemble to one memory port (optional MEM_ARB_FIXED_PRIO_EN)
module mem_arbiter_rr #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    parameter int BUS_WIDTH  = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_read,
    input  logic [NUM_PORTS-1:0]            req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata,
    output logic [LINE_WIDTH-1:0]           req_rdata,
    output logic [NUM_PORTS-1:0]            req_resp,
    output logic [NUM_PORTS-1:0]            grant,
    output logic                            pmem_read,
    output logic                            pmem_write,
    output logic [ADDR_WIDTH-1:0]           pmem_addr,
    output logic [BUS_WIDTH-1:0]            pmem_wdata,
    input  logic [BUS_WIDTH-1:0]            pmem_rdata,
    input  logic                            pmem_resp
);

    localparam int BEATS  = LINE_WIDTH / BUS_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESP} state_t;

    state_t                 state, state_next;
    logic [NUM_PORTS-1:0]   req_any;
    logic [IDX_W-1:0]       search_start;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_found;
    logic [IDX_W-1:0]       win_q;
    logic [ADDR_WIDTH-1:0]  sel_addr, addr_q;
    logic [LINE_WIDTH-1:0]  sel_wline, wline_q;
    logic [LINE_WIDTH-1:0]  rbuf_q, rbuf_next, rdata_q;
    logic [BUS_WIDTH-1:0]   wbeat;
    logic [BEAT_W-1:0]      beat;
    logic                   last_beat;
    logic [NUM_PORTS-1:0]   win_onehot;

    assign req_any   = req_read | req_write;
    assign last_beat = pmem_resp && (beat == LAST_BEAT);

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign search_start = '0;
`else
    localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);
    logic [IDX_W-1:0] rr_ptr;

    // Round-robin pointer moves just past the port that was last served
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (state == ST_RESP) begin
            rr_ptr <= (win_q == LAST_PORT) ? '0 : win_q + 1'b1;
        end
    end

    assign search_start = rr_ptr;
`endif

    // Winner: first requesting port at or above the search start, wrapping
    always_comb begin
        int idx;
        win_idx   = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(search_start) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!win_found && req_any[IDX_W'(idx)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(idx);
            end
        end
    end

    // Mux the winner's address/line and the current beat slices with constant bases
    always_comb begin
        sel_addr  = '0;
        sel_wline = '0;
        wbeat     = '0;
        rbuf_next = rbuf_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (win_idx == IDX_W'(p)) begin
                sel_addr  = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wline = req_wdata[p*LINE_WIDTH +: LINE_WIDTH];
            end
        end
        for (int b = 0; b < BEATS; b++) begin
            if (beat == BEAT_W'(b)) begin
                wbeat = wline_q[b*BUS_WIDTH +: BUS_WIDTH];
                if (state == ST_READ && pmem_resp) begin
                    rbuf_next[b*BUS_WIDTH +: BUS_WIDTH] = pmem_rdata;
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: write wins over read on the same port; last accepted beat ends the burst
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (win_found) begin
                    state_next = req_write[win_idx] ? ST_WRITE : ST_READ;
                end
            end
            ST_READ:  if (last_beat) state_next = ST_RESP;
            ST_WRITE: if (last_beat) state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Latch the transaction, count beats, publish the read line only once complete
    always_ff @(posedge clk) begin
        if (rst) begin
            beat    <= '0;
            win_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    beat <= '0;
                    if (win_found) begin
                        win_q   <= win_idx;
                        addr_q  <= sel_addr;
                        wline_q <= sel_wline;
                    end
                end
                ST_READ: begin
                    if (pmem_resp) begin
                        rbuf_q <= rbuf_next;
                        beat   <= last_beat ? '0 : beat + 1'b1;
                        if (last_beat) rdata_q <= rbuf_next;
                    end
                end
                ST_WRITE: begin
                    if (pmem_resp) beat <= last_beat ? '0 : beat + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign win_onehot = NUM_PORTS'(1) << win_q;
    assign grant      = (state != ST_IDLE) ? win_onehot : '0;
    assign req_resp   = (state == ST_RESP) ? win_onehot : '0;
    assign req_rdata  = rdata_q;
    assign pmem_read  = (state == ST_READ);
    assign pmem_write = (state == ST_WRITE);
    assign pmem_addr  = (state != ST_IDLE) ? addr_q : '0;
    assign pmem_wdata = (state == ST_WRITE) ? wbeat : '0;

endmodule
